// File: rtl/stall_resume_ctrl.sv
// Responder for the decode-stage branch/dmem stall handshake: tracks one open stall,
// returns a one-cycle resume pulse and holds fetch. Optional perf counters: STALL_PERF_CNT_EN.
module stall_resume_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_stall,
   input  logic        dmem_stall,
   input  logic        branch_done,
   input  logic        dmem_ack,
   output logic        branch_resume,
   output logic        dmem_resume,
   output logic        fetch_hold,
   output logic        busy,
   output logic        timeout_err,
   output logic [31:0] br_stall_cyc,
   output logic [31:0] dm_stall_cyc
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DM_WAIT   = 3'd1,
      S_BR_WAIT   = 3'd2,
      S_DM_RESUME = 3'd3,
      S_BR_RESUME = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic             br_res_q, dm_res_q;
   logic             timeout_hit;
   logic [CNT_W-1:0] wait_cnt_inc;

   assign timeout_hit  = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
   // Saturating increment so the wait counter can never wrap.
   assign wait_cnt_inc = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      fetch_hold = 1'b0;
      case (state_q)
         S_IDLE: begin
            fetch_hold = branch_stall | dmem_stall;
            wait_cnt_d = '0;
            if (dmem_stall) begin
               state_d = dmem_ack ? S_DM_RESUME : S_DM_WAIT;
            end else if (branch_stall) begin
               state_d = branch_done ? S_BR_RESUME : S_BR_WAIT;
            end
         end
         S_DM_WAIT: begin
            fetch_hold = 1'b1;
            // A dropped stall is abandoned silently and wins over a same-cycle ack.
            if (!dmem_stall) begin
               state_d = S_IDLE;
            end else if (dmem_ack) begin
               state_d = S_DM_RESUME;
            end else if (timeout_hit) begin
               state_d = S_DM_RESUME;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         S_BR_WAIT: begin
            fetch_hold = 1'b1;
            if (!branch_stall) begin
               state_d = S_IDLE;
            end else if (branch_done) begin
               state_d = S_BR_RESUME;
            end else if (timeout_hit) begin
               state_d = S_BR_RESUME;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         S_DM_RESUME, S_BR_RESUME: begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
         end
      endcase
      if (rst) begin
         fetch_hold = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         br_res_q   <= 1'b0;
         dm_res_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         br_res_q   <= (state_d == S_BR_RESUME);
         dm_res_q   <= (state_d == S_DM_RESUME);
      end
   end

   assign branch_resume = br_res_q;
   assign dmem_resume   = dm_res_q;
   assign timeout_err   = err_q;
   assign busy          = (state_q != S_IDLE);

`ifdef STALL_PERF_CNT_EN
   logic [31:0] br_cyc_q, dm_cyc_q;

   // Free-running wait-cycle counters, wrapping modulo 2**32.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cyc_q <= 32'h0;
         dm_cyc_q <= 32'h0;
      end else begin
         if (state_q == S_BR_WAIT) begin
            br_cyc_q <= br_cyc_q + 32'd1;
         end
         if (state_q == S_DM_WAIT) begin
            dm_cyc_q <= dm_cyc_q + 32'd1;
         end
      end
   end

   assign br_stall_cyc = br_cyc_q;
   assign dm_stall_cyc = dm_cyc_q;
`else
   assign br_stall_cyc = 32'h0;
   assign dm_stall_cyc = 32'h0;
`endif

endmodule

// File: tb/tb_stall_resume_ctrl.sv
// Bench for stall_resume_ctrl: directed scenarios with literal expectations plus a
// randomized decode/execute/memory environment checked against a transaction-level model.
module tb_stall_resume_ctrl;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bs = 1'b0, ds = 1'b0, bd = 1'b0, ack = 1'b0;
   logic        branch_resume, dmem_resume, fetch_hold, busy, timeout_err;
   logic [31:0] br_stall_cyc, dm_stall_cyc;

   always #5 clk = ~clk;

   stall_resume_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .branch_stall  (bs),
      .dmem_stall    (ds),
      .branch_done   (bd),
      .dmem_ack      (ack),
      .branch_resume (branch_resume),
      .dmem_resume   (dmem_resume),
      .fetch_hold    (fetch_hold),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .br_stall_cyc  (br_stall_cyc),
      .dm_stall_cyc  (dm_stall_cyc)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model: which stall is being tracked (0 none, 1 dmem, 2 branch), how many
   // cycles it has waited, and which resume (if any) is being returned this cycle.
   int          m_open = 0;
   int          m_waited = 0;
   int          m_res = 0;
   logic        m_err = 1'b0;
   logic [31:0] m_br = 32'h0;
   logic [31:0] m_dm = 32'h0;

`ifdef STALL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic e_fh;
      e_fh = rst ? 1'b0 : ((m_open != 0) || (m_res == 0 && (bs || ds)));
      chk("busy",          32'(busy),          32'((m_open != 0) || (m_res != 0)));
      chk("fetch_hold",    32'(fetch_hold),    32'(e_fh));
      chk("branch_resume", 32'(branch_resume), 32'(m_res == 2));
      chk("dmem_resume",   32'(dmem_resume),   32'(m_res == 1));
      chk("timeout_err",   32'(timeout_err),   32'(m_err));
      chk("br_stall_cyc",  br_stall_cyc,       PERF ? m_br : 32'h0);
      chk("dm_stall_cyc",  dm_stall_cyc,       PERF ? m_dm : 32'h0);
   endtask

   // Advance the model by one clock using the inputs held during the cycle.
   task automatic model_update();
      logic lvl, ev;
      if (rst) begin
         m_open = 0; m_waited = 0; m_res = 0; m_err = 1'b0; m_br = 32'h0; m_dm = 32'h0;
      end else if (m_res != 0) begin
         m_res = 0;
      end else if (m_open == 0) begin
         if (ds) begin
            if (ack) m_res = 1; else begin m_open = 1; m_waited = 0; end
         end else if (bs) begin
            if (bd) m_res = 2; else begin m_open = 2; m_waited = 0; end
         end
      end else begin
         if (m_open == 1) m_dm = m_dm + 32'd1; else m_br = m_br + 32'd1;
         lvl = (m_open == 1) ? ds : bs;
         ev  = (m_open == 1) ? ack : bd;
         m_waited++;
         if (!lvl) begin
            m_open = 0;
         end else if (ev) begin
            m_res = m_open; m_open = 0;
         end else if (m_waited == int'(TIMEOUT)) begin
            m_res = m_open; m_open = 0; m_err = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic b, input logic d, input logic bdn, input logic a);
      @(negedge clk);
      rst = r; bs = b; ds = d; bd = bdn; ack = a;
      #1;
      if (chk_en) model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
   endtask

   int  prev_res;
   logic nb, nd;

   initial begin
      // Reset held two cycles with both stalls high
      step(1, 1, 1, 0, 0); adv();
      chk_en = 1'b1;
      step(1, 1, 1, 0, 0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fetch_hold", 32'(fetch_hold), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      adv();

      // Branch stall resolved at c3
      step(0, 1, 0, 0, 0); chk("s2_c0_fh", 32'(fetch_hold), 32'd1); chk("s2_c0_busy", 32'(busy), 32'd0); adv();
      step(0, 1, 0, 0, 0); chk("s2_c1_busy", 32'(busy), 32'd1); adv();
      step(0, 1, 0, 0, 0); adv();
      step(0, 1, 0, 1, 0); chk("s2_c3_fh", 32'(fetch_hold), 32'd1); chk("s2_c3_res", 32'(branch_resume), 32'd0); adv();
      step(0, 1, 0, 0, 0); chk("s2_c4_res", 32'(branch_resume), 32'd1); chk("s2_c4_fh", 32'(fetch_hold), 32'd0); adv();
      step(0, 0, 0, 0, 0);
      chk("s2_c5_res", 32'(branch_resume), 32'd0);
      chk("s2_c5_busy", 32'(busy), 32'd0);
      chk("s2_c5_err", 32'(timeout_err), 32'd0);
      chk("s2_br_cyc", br_stall_cyc, PERF ? 32'd3 : 32'd0);
      chk("s2_dm_cyc", dm_stall_cyc, 32'd0);
      adv();

      // Dmem stall with no ack times out 16 cycles after DM_WAIT entry
      for (int k = 0; k < 18; k++) begin
         step(0, 0, 1, 0, 0);
         if (k == 16) chk("s3_c16_res", 32'(dmem_resume), 32'd0);
         if (k == 17) begin
            chk("s3_c17_res", 32'(dmem_resume), 32'd1);
            chk("s3_c17_err", 32'(timeout_err), 32'd1);
         end
         adv();
      end
      step(0, 0, 0, 0, 0);
      chk("s3_err_sticky", 32'(timeout_err), 32'd1);
      chk("s3_dm_cyc", dm_stall_cyc, PERF ? 32'd16 : 32'd0);
      adv();

      // Both stalls: dmem first, branch taken afterwards
      step(0, 1, 1, 0, 0); adv();
      step(0, 1, 1, 0, 0); adv();
      step(0, 1, 1, 0, 1); adv();
      step(0, 1, 1, 0, 0); chk("s4_c3_dres", 32'(dmem_resume), 32'd1); chk("s4_c3_bres", 32'(branch_resume), 32'd0); adv();
      step(0, 1, 0, 0, 0); chk("s4_c4_busy", 32'(busy), 32'd0); adv();
      step(0, 1, 0, 0, 0); chk("s4_c5_busy", 32'(busy), 32'd1); adv();
      step(0, 1, 0, 1, 0); adv();
      step(0, 1, 0, 0, 0); chk("s4_c7_bres", 32'(branch_resume), 32'd1); adv();
      step(0, 0, 0, 0, 0); adv();

      // Reset during DM_WAIT abandons the stall
      step(0, 0, 1, 0, 0); adv();
      step(0, 0, 1, 0, 0); chk("s5_c1_busy", 32'(busy), 32'd1); adv();
      step(1, 0, 1, 0, 0); adv();
      step(0, 0, 0, 0, 1);
      chk("s5_c3_busy", 32'(busy), 32'd0);
      chk("s5_c3_res", 32'(dmem_resume), 32'd0);
      chk("s5_c3_err", 32'(timeout_err), 32'd0);
      adv();
      step(0, 0, 0, 0, 0); chk("s5_c4_res", 32'(dmem_resume), 32'd0); adv();

      // Randomized decode/execute/memory traffic
      prev_res = 0;
      for (int i = 0; i < 4000; i++) begin
         nd = ds;
         nb = bs;
         if (prev_res == 1) nd = 1'b0;
         else if (!ds && $urandom_range(0, 5) == 0) nd = 1'b1;
         else if (ds && $urandom_range(0, 79) == 0) nd = 1'b0;
         if (prev_res == 2) nb = 1'b0;
         else if (!bs && $urandom_range(0, 5) == 0) nb = 1'b1;
         else if (bs && $urandom_range(0, 79) == 0) nb = 1'b0;
         step(logic'($urandom_range(0, 299) == 0), nb, nd,
              logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0));
         prev_res = m_res;
         adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
